id_ex_stage: RTL and testbench

Decode-to-execute pipeline register with operand forwarding and load-use hazard control. Captures decoded fields plus the two 32-bit operands read combinationally from the 16-entry register file. Substitutes newer results from the EX and MEM stages, and inserts a one-cycle bubble when an instruction consumes a load result still in EX. Sits between decode/register-file read and the ALU.

---
 rtl/id_ex_stage_pkg.sv | 25 ++
 rtl/id_ex_stage_if.sv | 65 ++++++
 rtl/id_ex_stage_fwd_mux.sv | 33 +++
 rtl/id_ex_stage.sv | 96 +++++++++
 tb/tb_id_ex_stage.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared types and widths for the decode-to-execute pipeline register.
// All widths used by the stage, its interface and its operand muxes come from here.
package id_ex_stage_pkg;

    localparam int DW  = 32;
    localparam int RW  = 4;
    localparam int OPW = 6;

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } state_e;

    typedef struct packed {
        logic           valid;
        logic [OPW-1:0] opcode;
        logic [RW-1:0]  rd;
        logic           writes_rd;
        logic           is_load;
        logic [DW-1:0]  a;
        logic [DW-1:0]  b;
        logic [DW-1:0]  imm;
    } id_ex_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Signal bundle between decode/register-file read, the EX/MEM status taps and the
// ID/EX pipeline register. master = surrounding pipeline, slave = the stage.
interface id_ex_stage_if;
    import id_ex_stage_pkg::*;

    // Flow control: ex_out_valid qualifies the ex_out_* fields. stall_in=1 freezes
    // the stage; stall_id=1 tells fetch/decode to hold its current instruction.
    logic           id_valid;
    logic [OPW-1:0] id_opcode;
    logic [RW-1:0]  id_rs1;
    logic [RW-1:0]  id_rs2;
    logic           id_uses_rs1;
    logic           id_uses_rs2;
    logic [RW-1:0]  id_rd;
    logic           id_writes_rd;
    logic           id_is_load;
    logic [DW-1:0]  id_imm;
    logic [DW-1:0]  rf_data1;
    logic [DW-1:0]  rf_data2;

    logic           ex_valid;
    logic           ex_writes_rd;
    logic           ex_is_load;
    logic [RW-1:0]  ex_rd;
    logic [DW-1:0]  ex_result;

    logic           mem_valid;
    logic           mem_writes_rd;
    logic [RW-1:0]  mem_rd;
    logic [DW-1:0]  mem_result;

    logic           flush;
    logic           stall_in;
    logic           stall_id;

    logic           ex_out_valid;
    logic [OPW-1:0] ex_out_opcode;
    logic [RW-1:0]  ex_out_rd;
    logic           ex_out_writes_rd;
    logic           ex_out_is_load;
    logic [DW-1:0]  ex_out_a;
    logic [DW-1:0]  ex_out_b;
    logic [DW-1:0]  ex_out_imm;
    logic [31:0]    bubble_count;
    state_e         state;

    modport master (
        output id_valid, id_opcode, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               id_rd, id_writes_rd, id_is_load, id_imm, rf_data1, rf_data2,
               ex_valid, ex_writes_rd, ex_is_load, ex_rd, ex_result,
               mem_valid, mem_writes_rd, mem_rd, mem_result, flush, stall_in,
        input  stall_id, ex_out_valid, ex_out_opcode, ex_out_rd, ex_out_writes_rd,
               ex_out_is_load, ex_out_a, ex_out_b, ex_out_imm, bubble_count, state
    );

    modport slave (
        input  id_valid, id_opcode, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               id_rd, id_writes_rd, id_is_load, id_imm, rf_data1, rf_data2,
               ex_valid, ex_writes_rd, ex_is_load, ex_rd, ex_result,
               mem_valid, mem_writes_rd, mem_rd, mem_result, flush, stall_in,
        output stall_id, ex_out_valid, ex_out_opcode, ex_out_rd, ex_out_writes_rd,
               ex_out_is_load, ex_out_a, ex_out_b, ex_out_imm, bubble_count, state
    );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-source operand selection: EX ALU result, then MEM result, then register file.
// A load in EX is never a source here; its data only exists once it reaches MEM.
module fwd_mux
    import id_ex_stage_pkg::*;
(
    input  logic [RW-1:0] rs,
    input  logic          uses,
    input  logic          ex_valid,
    input  logic          ex_writes_rd,
    input  logic          ex_is_load,
    input  logic [RW-1:0] ex_rd,
    input  logic [DW-1:0] ex_result,
    input  logic          mem_valid,
    input  logic          mem_writes_rd,
    input  logic [RW-1:0] mem_rd,
    input  logic [DW-1:0] mem_result,
    input  logic [DW-1:0] rf_data,
    output logic [DW-1:0] operand
);

    logic hit_ex;
    logic hit_mem;

    assign hit_ex  = uses & ex_valid & ex_writes_rd & ~ex_is_load & (ex_rd == rs);
    assign hit_mem = uses & mem_valid & mem_writes_rd & (mem_rd == rs);

    always_comb begin
        operand = rf_data;
        if (hit_ex)       operand = ex_result;
        else if (hit_mem) operand = mem_result;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM operand forwarding and a one-cycle
// load-use bubble. Edge priority: reset > flush > stall_in > load-use > capture.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input logic          clk,
    input logic          reset,
    id_ex_stage_if.slave bus
);

    logic [DW-1:0] fwd_a;
    logic [DW-1:0] fwd_b;
    logic          luh;
    id_ex_t        r;
    state_e        state;
    logic [31:0]   bubble_count;

    fwd_mux u_fwd_a (
        .rs            (bus.id_rs1),
        .uses          (bus.id_uses_rs1),
        .ex_valid      (bus.ex_valid),
        .ex_writes_rd  (bus.ex_writes_rd),
        .ex_is_load    (bus.ex_is_load),
        .ex_rd         (bus.ex_rd),
        .ex_result     (bus.ex_result),
        .mem_valid     (bus.mem_valid),
        .mem_writes_rd (bus.mem_writes_rd),
        .mem_rd        (bus.mem_rd),
        .mem_result    (bus.mem_result),
        .rf_data       (bus.rf_data1),
        .operand       (fwd_a)
    );

    fwd_mux u_fwd_b (
        .rs            (bus.id_rs2),
        .uses          (bus.id_uses_rs2),
        .ex_valid      (bus.ex_valid),
        .ex_writes_rd  (bus.ex_writes_rd),
        .ex_is_load    (bus.ex_is_load),
        .ex_rd         (bus.ex_rd),
        .ex_result     (bus.ex_result),
        .mem_valid     (bus.mem_valid),
        .mem_writes_rd (bus.mem_writes_rd),
        .mem_rd        (bus.mem_rd),
        .mem_result    (bus.mem_result),
        .rf_data       (bus.rf_data2),
        .operand       (fwd_b)
    );

    assign luh = bus.id_valid & bus.ex_valid & bus.ex_is_load & bus.ex_writes_rd &
                 ((bus.id_uses_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                  (bus.id_uses_rs2 & (bus.id_rs2 == bus.ex_rd)));

    assign bus.stall_id = ~bus.flush & (bus.stall_in | ((state == RUN) & luh));

    // In BUBBLE the load has moved to MEM, so luh is ignored and the MEM path feeds it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r            <= '0;
            state        <= RUN;
            bubble_count <= '0;
        end else if (bus.flush) begin
            r.valid <= 1'b0;
            state   <= RUN;
        end else if (bus.stall_in) begin
            r     <= r;
            state <= state;
        end else if ((state == RUN) && luh) begin
            r.valid <= 1'b0;
            state   <= BUBBLE;
            if (bubble_count != 32'hFFFF_FFFF) bubble_count <= bubble_count + 32'd1;
        end else begin
            r.valid     <= bus.id_valid;
            r.opcode    <= bus.id_opcode;
            r.rd        <= bus.id_rd;
            r.writes_rd <= bus.id_writes_rd;
            r.is_load   <= bus.id_is_load;
            r.a         <= fwd_a;
            r.b         <= fwd_b;
            r.imm       <= bus.id_imm;
            state       <= RUN;
        end
    end

    assign bus.ex_out_valid     = r.valid;
    assign bus.ex_out_opcode    = r.opcode;
    assign bus.ex_out_rd        = r.rd;
    assign bus.ex_out_writes_rd = r.writes_rd;
    assign bus.ex_out_is_load   = r.is_load;
    assign bus.ex_out_a         = r.a;
    assign bus.ex_out_b         = r.b;
    assign bus.ex_out_imm       = r.imm;
    assign bus.bubble_count     = bubble_count;
    assign bus.state            = state;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed forwarding/hazard scenarios plus a random
// forwarding sweep, with captured {valid, a, b} checked against an expected queue.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   exp_bubbles = 0;

    logic [64:0] exp_q[$];
    logic [64:0] exp_v;
    logic [64:0] got_v;
    logic [31:0] hold_a;

    id_ex_stage_if bus();

    id_ex_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.id_valid = 0; bus.id_opcode = '0; bus.id_rs1 = '0; bus.id_rs2 = '0;
        bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0; bus.id_rd = '0;
        bus.id_writes_rd = 0; bus.id_is_load = 0; bus.id_imm = '0;
        bus.rf_data1 = '0; bus.rf_data2 = '0;
        bus.ex_valid = 0; bus.ex_writes_rd = 0; bus.ex_is_load = 0;
        bus.ex_rd = '0; bus.ex_result = '0;
        bus.mem_valid = 0; bus.mem_writes_rd = 0; bus.mem_rd = '0; bus.mem_result = '0;
        bus.flush = 0; bus.stall_in = 0;
    endtask

    task automatic set_id(input logic [3:0] rs1, input logic [3:0] rs2,
                          input logic [31:0] rf1, input logic [31:0] rf2);
        bus.id_valid = 1; bus.id_opcode = 6'h2A; bus.id_rd = 4'hE;
        bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_uses_rs1 = 1; bus.id_uses_rs2 = 1;
        bus.id_writes_rd = 1; bus.id_is_load = 0; bus.id_imm = 32'hFFFF_FFF0;
        bus.rf_data1 = rf1; bus.rf_data2 = rf2;
    endtask

    task automatic set_ex(input logic v, input logic w, input logic ld,
                          input logic [3:0] rd, input logic [31:0] res);
        bus.ex_valid = v; bus.ex_writes_rd = w; bus.ex_is_load = ld;
        bus.ex_rd = rd; bus.ex_result = res;
    endtask

    task automatic set_mem(input logic v, input logic w,
                           input logic [3:0] rd, input logic [31:0] res);
        bus.mem_valid = v; bus.mem_writes_rd = w; bus.mem_rd = rd; bus.mem_result = res;
    endtask

    // Drives a load r2 in EX against a decode reading r2, leaving the stage in BUBBLE.
    task automatic make_bubble();
        @(negedge clk);
        idle_inputs();
        set_id(4'd2, 4'd9, 32'h0000_0BAD, 32'h0000_0099);
        set_ex(1, 1, 1, 4'd2, 32'h0000_0F00);
        exp_bubbles++;
        tick();
    endtask

    function automatic logic [31:0] model_fwd(input logic [3:0] rs, input logic [31:0] rf);
        if (bus.ex_valid && bus.ex_writes_rd && !bus.ex_is_load && bus.ex_rd == rs)
            return bus.ex_result;
        if (bus.mem_valid && bus.mem_writes_rd && bus.mem_rd == rs)
            return bus.mem_result;
        return rf;
    endfunction

    task automatic test_reset();
        reset = 1;
        idle_inputs();
        #12;
        checks++;
        if ({bus.ex_out_valid, bus.ex_out_opcode, bus.ex_out_rd, bus.ex_out_writes_rd,
             bus.ex_out_is_load, bus.ex_out_a, bus.ex_out_b, bus.ex_out_imm} !== '0) begin
            errors++; $display("FAIL reset_outputs a=%h b=%h imm=%h valid=%b expected all zero",
                               bus.ex_out_a, bus.ex_out_b, bus.ex_out_imm, bus.ex_out_valid);
        end
        checks++;
        if (bus.bubble_count !== 32'd0 || bus.state !== RUN || bus.stall_id !== 1'b0) begin
            errors++; $display("FAIL reset_state count=%0d state=%0d stall_id=%b expected 0/RUN/0",
                               bus.bubble_count, bus.state, bus.stall_id);
        end
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_ex_forward();
        @(negedge clk);
        idle_inputs();
        set_id(4'd3, 4'd7, 32'h0, 32'h0000_0077);
        set_ex(1, 1, 0, 4'd3, 32'h0000_0011);
        exp_q.push_back({1'b1, 32'h0000_0011, 32'h0000_0077});
        #1;
        checks++;
        if (bus.stall_id !== 1'b0) begin
            errors++; $display("FAIL ex_fwd_stall stall_id=%b expected 0", bus.stall_id);
        end
        tick();
        got_v = {bus.ex_out_valid, bus.ex_out_a, bus.ex_out_b};
        exp_v = exp_q.pop_front();
        checks++;
        if (got_v !== exp_v) begin
            errors++; $display("FAIL ex_fwd got=%h expected=%h", got_v, exp_v);
        end
        checks++;
        if (bus.ex_out_opcode !== 6'h2A || bus.ex_out_rd !== 4'hE ||
            bus.ex_out_imm !== 32'hFFFF_FFF0 || bus.ex_out_writes_rd !== 1'b1) begin
            errors++; $display("FAIL ex_fwd_fields op=%h rd=%h imm=%h wr=%b expected 2a/e/fffffff0/1",
                               bus.ex_out_opcode, bus.ex_out_rd, bus.ex_out_imm, bus.ex_out_writes_rd);
        end
    endtask

    task automatic test_priority();
        @(negedge clk);
        idle_inputs();
        set_id(4'd1, 4'd5, 32'h0000_0001, 32'h0000_0055);
        set_ex(1, 1, 0, 4'd5, 32'h0000_0022);
        set_mem(1, 1, 4'd5, 32'h0000_0033);
        exp_q.push_back({1'b1, 32'h0000_0001, 32'h0000_0022});
        tick();
        got_v = {bus.ex_out_valid, bus.ex_out_a, bus.ex_out_b};
        exp_v = exp_q.pop_front();
        checks++;
        if (got_v !== exp_v) begin
            errors++; $display("FAIL prio_ex_over_mem got=%h expected=%h", got_v, exp_v);
        end
        @(negedge clk);
        set_ex(0, 0, 0, 4'd0, 32'h0);
        exp_q.push_back({1'b1, 32'h0000_0001, 32'h0000_0033});
        tick();
        got_v = {bus.ex_out_valid, bus.ex_out_a, bus.ex_out_b};
        exp_v = exp_q.pop_front();
        checks++;
        if (got_v !== exp_v) begin
            errors++; $display("FAIL prio_mem_only got=%h expected=%h", got_v, exp_v);
        end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        idle_inputs();
        set_id(4'd2, 4'd9, 32'h0000_0BAD, 32'h0000_0099);
        set_ex(1, 1, 1, 4'd2, 32'h0000_0F00);
        exp_bubbles++;
        #1;
        checks++;
        if (bus.stall_id !== 1'b1) begin
            errors++; $display("FAIL luh_stall stall_id=%b expected 1", bus.stall_id);
        end
        tick();
        checks++;
        if (bus.ex_out_valid !== 1'b0 || bus.state !== BUBBLE || bus.bubble_count !== exp_bubbles) begin
            errors++; $display("FAIL luh_bubble valid=%b state=%0d count=%0d expected 0/BUBBLE/%0d",
                               bus.ex_out_valid, bus.state, bus.bubble_count, exp_bubbles);
        end
        @(negedge clk);
        set_ex(0, 0, 0, 4'd0, 32'h0);
        set_mem(1, 1, 4'd2, 32'h0000_DEAD);
        exp_q.push_back({1'b1, 32'h0000_DEAD, 32'h0000_0099});
        #1;
        checks++;
        if (bus.stall_id !== 1'b0) begin
            errors++; $display("FAIL luh_release_stall stall_id=%b expected 0", bus.stall_id);
        end
        tick();
        got_v = {bus.ex_out_valid, bus.ex_out_a, bus.ex_out_b};
        exp_v = exp_q.pop_front();
        checks++;
        if (got_v !== exp_v || bus.state !== RUN || bus.bubble_count !== exp_bubbles) begin
            errors++; $display("FAIL luh_mem_fwd got=%h state=%0d count=%0d expected=%h RUN %0d",
                               got_v, bus.state, bus.bubble_count, exp_v, exp_bubbles);
        end
    endtask

    task automatic test_flush_bubble();
        make_bubble();
        hold_a = bus.ex_out_a;
        @(negedge clk);
        bus.flush = 1;
        set_ex(0, 0, 0, 4'd0, 32'h0);
        set_mem(1, 1, 4'd2, 32'h0000_BEEF);
        #1;
        checks++;
        if (bus.stall_id !== 1'b0) begin
            errors++; $display("FAIL flush_stall stall_id=%b expected 0", bus.stall_id);
        end
        tick();
        checks++;
        if (bus.ex_out_valid !== 1'b0 || bus.state !== RUN || bus.bubble_count !== exp_bubbles ||
            bus.ex_out_a !== hold_a) begin
            errors++; $display("FAIL flush_bubble valid=%b state=%0d count=%0d a=%h expected 0/RUN/%0d/%h",
                               bus.ex_out_valid, bus.state, bus.bubble_count, bus.ex_out_a,
                               exp_bubbles, hold_a);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_stall_in();
        @(negedge clk);
        idle_inputs();
        set_id(4'd1, 4'd4, 32'h0000_0100, 32'h0000_0400);
        exp_q.push_back({1'b1, 32'h0000_0100, 32'h0000_0400});
        tick();
        got_v = {bus.ex_out_valid, bus.ex_out_a, bus.ex_out_b};
        exp_v = exp_q.pop_front();
        checks++;
        if (got_v !== exp_v) begin
            errors++; $display("FAIL stall_pre got=%h expected=%h", got_v, exp_v);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.stall_in = 1;
            set_id(4'd1, 4'd4, $urandom, $urandom);
            #1;
            checks++;
            if (bus.stall_id !== 1'b1) begin
                errors++; $display("FAIL stall_in_id cycle=%0d stall_id=%b expected 1", i, bus.stall_id);
            end
            tick();
            got_v = {bus.ex_out_valid, bus.ex_out_a, bus.ex_out_b};
            checks++;
            if (got_v !== exp_v) begin
                errors++; $display("FAIL stall_in_frozen cycle=%0d got=%h expected=%h", i, got_v, exp_v);
            end
        end
        @(negedge clk);
        bus.stall_in = 0;
        set_id(4'd1, 4'd4, 32'h0000_0111, 32'h0000_0444);
        set_mem(1, 1, 4'd4, 32'h0000_4444);
        exp_q.push_back({1'b1, 32'h0000_0111, 32'h0000_4444});
        tick();
        got_v = {bus.ex_out_valid, bus.ex_out_a, bus.ex_out_b};
        exp_v = exp_q.pop_front();
        checks++;
        if (got_v !== exp_v) begin
            errors++; $display("FAIL stall_release got=%h expected=%h", got_v, exp_v);
        end
    endtask

    task automatic test_stall_in_bubble();
        make_bubble();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.stall_in = 1;
            set_ex(0, 0, 0, 4'd0, 32'h0);
            set_mem(1, 1, 4'd2, 32'h0000_CAFE);
            tick();
            checks++;
            if (bus.state !== BUBBLE || bus.ex_out_valid !== 1'b0) begin
                errors++; $display("FAIL stall_bubble_hold cycle=%0d state=%0d valid=%b expected BUBBLE/0",
                                   i, bus.state, bus.ex_out_valid);
            end
        end
        @(negedge clk);
        bus.stall_in = 0;
        exp_q.push_back({1'b1, 32'h0000_CAFE, 32'h0000_0099});
        tick();
        got_v = {bus.ex_out_valid, bus.ex_out_a, bus.ex_out_b};
        exp_v = exp_q.pop_front();
        checks++;
        if (got_v !== exp_v || bus.state !== RUN || bus.bubble_count !== exp_bubbles) begin
            errors++; $display("FAIL stall_bubble_release got=%h state=%0d count=%0d expected=%h RUN %0d",
                               got_v, bus.state, bus.bubble_count, exp_v, exp_bubbles);
        end
    endtask

    task automatic test_reset_mid_bubble();
        make_bubble();
        @(negedge clk);
        #2;
        reset = 1;
        #1;
        exp_bubbles = 0;
        checks++;
        if (bus.state !== RUN || bus.bubble_count !== 32'd0 || bus.ex_out_valid !== 1'b0 ||
            bus.ex_out_a !== 32'd0) begin
            errors++; $display("FAIL reset_mid_bubble state=%0d count=%0d valid=%b a=%h expected RUN/0/0/0",
                               bus.state, bus.bubble_count, bus.ex_out_valid, bus.ex_out_a);
        end
        idle_inputs();
        #1;
        checks++;
        if (bus.stall_id !== 1'b0) begin
            errors++; $display("FAIL reset_stall_id stall_id=%b expected 0", bus.stall_id);
        end
        @(negedge clk);
        reset = 0;
        set_id(4'd6, 4'd8, 32'h0000_0066, 32'h0000_0088);
        exp_q.push_back({1'b1, 32'h0000_0066, 32'h0000_0088});
        tick();
        got_v = {bus.ex_out_valid, bus.ex_out_a, bus.ex_out_b};
        exp_v = exp_q.pop_front();
        checks++;
        if (got_v !== exp_v) begin
            errors++; $display("FAIL post_reset_capture got=%h expected=%h", got_v, exp_v);
        end
    endtask

    task automatic test_random_forwarding();
        logic [3:0] rs1, rs2;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            idle_inputs();
            rs1 = 4'($urandom_range(0, 3));
            rs2 = 4'($urandom_range(0, 3));
            set_id(rs1, rs2, $urandom, $urandom);
            set_ex(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
                   4'($urandom_range(0, 3)), $urandom);
            set_mem(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 3)), $urandom);
            exp_q.push_back({1'b1, model_fwd(rs1, bus.rf_data1), model_fwd(rs2, bus.rf_data2)});
            tick();
            got_v = {bus.ex_out_valid, bus.ex_out_a, bus.ex_out_b};
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL random_empty_queue cycle=%0d got=%h expected an entry", i, got_v);
            end else begin
                exp_v = exp_q.pop_front();
                if (got_v !== exp_v) begin
                    errors++; $display("FAIL random_fwd cycle=%0d got=%h expected=%h", i, got_v, exp_v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ex_forward();
        test_priority();
        test_load_use();
        test_flush_bubble();
        test_stall_in();
        test_stall_in_bubble();
        test_reset_mid_bubble();
        test_random_forwarding();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain left=%0d expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
